// File: rtl/hex_search_controller.sv
// Hexagon-pattern motion search sequencer: issues fetches around the current centre,
// walks toward the winning vertex and reports the final motion vector and SAD.
module hex_search_controller #(
   parameter int MV_W         = 6,
   parameter int SEARCH_RANGE = 16,
   parameter int MAX_ITER     = 8,
   parameter int SAD_W        = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             fetch_req,
   output logic [MV_W-1:0]  centre_x,
   output logic [MV_W-1:0]  centre_y,
   input  logic             fetch_done,
   input  logic [SAD_W-1:0] sad_min,
   input  logic [2:0]       new_centre,
   output logic             done,
   output logic [MV_W-1:0]  mv_x,
   output logic [MV_W-1:0]  mv_y,
   output logic [SAD_W-1:0] best_sad,
   output logic [3:0]       iter_count,
   output logic             hit_limit
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_EVAL,
      S_DONE
   } state_t;

   localparam logic signed [MV_W:0] LIM_POS  = (MV_W+1)'(SEARCH_RANGE);
   localparam logic signed [MV_W:0] LIM_NEG  = -LIM_POS;
   localparam logic [3:0]           ITER_CAP = 4'(MAX_ITER);

   // Clamp a widened component back into the search window.
   function automatic logic signed [MV_W-1:0] sat_comp(input logic signed [MV_W:0] v);
      if (v > LIM_POS)
         sat_comp = LIM_POS[MV_W-1:0];
      else if (v < LIM_NEG)
         sat_comp = LIM_NEG[MV_W-1:0];
      else
         sat_comp = v[MV_W-1:0];
   endfunction

   function automatic logic signed [2:0] off_x(input logic [2:0] idx);
      case (idx)
         3'd1:    off_x = 3'sd2;
         3'd2:    off_x = 3'sd1;
         3'd3:    off_x = -3'sd1;
         3'd4:    off_x = -3'sd2;
         3'd5:    off_x = -3'sd1;
         3'd6:    off_x = 3'sd1;
         default: off_x = 3'sd0;
      endcase
   endfunction

   function automatic logic signed [2:0] off_y(input logic [2:0] idx);
      case (idx)
         3'd2, 3'd3: off_y = 3'sd2;
         3'd5, 3'd6: off_y = -3'sd2;
         default:    off_y = 3'sd0;
      endcase
   endfunction

   state_t state, state_nx;

   logic signed [MV_W-1:0] cx_q, cy_q;
   logic signed [MV_W:0]   sum_x, sum_y;
   logic signed [MV_W-1:0] cand_x, cand_y;
   logic [3:0]             iter_inc;
   logic                   converged, stalled, last_iter;

   // Candidate centre for the current EVAL, computed one bit wider to avoid wrap.
   always_comb begin
      sum_x     = (MV_W+1)'(cx_q) + (MV_W+1)'(off_x(new_centre));
      sum_y     = (MV_W+1)'(cy_q) + (MV_W+1)'(off_y(new_centre));
      cand_x    = sat_comp(sum_x);
      cand_y    = sat_comp(sum_y);
      iter_inc  = iter_count + 4'd1;
      converged = (new_centre == 3'd0) || (new_centre == 3'd7);
      stalled   = !converged && (cand_x == cx_q) && (cand_y == cy_q);
      last_iter = (iter_inc == ITER_CAP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      busy      = (state != S_IDLE);
      fetch_req = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nx = S_ISSUE;
         S_ISSUE: begin
            fetch_req = 1'b1;
            state_nx  = S_WAIT;
         end
         S_WAIT:  if (fetch_done) state_nx = S_EVAL;
         S_EVAL:  state_nx = (converged || stalled || last_iter) ? S_DONE : S_ISSUE;
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cx_q       <= '0;
         cy_q       <= '0;
         mv_x       <= '0;
         mv_y       <= '0;
         best_sad   <= '0;
         iter_count <= '0;
         hit_limit  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cx_q       <= '0;
                  cy_q       <= '0;
                  mv_x       <= '0;
                  mv_y       <= '0;
                  best_sad   <= '0;
                  iter_count <= '0;
                  hit_limit  <= 1'b0;
               end
            end
            S_EVAL: begin
               best_sad   <= sad_min;
               iter_count <= iter_inc;
               if (converged || stalled) begin
                  mv_x <= cx_q;
                  mv_y <= cy_q;
               end else begin
                  cx_q <= cand_x;
                  cy_q <= cand_y;
                  if (last_iter) begin
                     mv_x      <= cand_x;
                     mv_y      <= cand_y;
                     hit_limit <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign centre_x = cx_q;
   assign centre_y = cy_q;

endmodule

// File: tb/tb_hex_search_controller.sv
// Scoreboard bench for hex_search_controller: expected fetch centres and results are
// queued by the stimulus; a forked monitor pops and compares on fetch_req and done.
module tb_hex_search_controller;

   localparam int MV_W  = 6;
   localparam int SAD_W = 12;

   typedef struct {
      int x;
      int y;
   } pt_t;

   typedef struct {
      int mvx;
      int mvy;
      int sad;
      int iter;
      int hit;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0;
   logic fetch_done = 1'b0;
   logic [SAD_W-1:0] sad_min = '0;
   logic [2:0] new_centre = '0;
   logic sel = 1'b0;

   logic busy_a, fetch_req_a, done_a, hit_a;
   logic [MV_W-1:0] cx_a, cy_a, mvx_a, mvy_a;
   logic [SAD_W-1:0] bsad_a;
   logic [3:0] iter_a;

   logic busy_b, fetch_req_b, done_b, hit_b;
   logic [MV_W-1:0] cx_b, cy_b, mvx_b, mvy_b;
   logic [SAD_W-1:0] bsad_b;
   logic [3:0] iter_b;

   int checks = 0;
   int errors = 0;
   pt_t  exp_fetch[$];
   res_t exp_done[$];

   always #5 clk = ~clk;

   hex_search_controller #(.MV_W(MV_W), .SEARCH_RANGE(16), .MAX_ITER(8), .SAD_W(SAD_W)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .fetch_req(fetch_req_a),
      .centre_x(cx_a), .centre_y(cy_a), .fetch_done(fetch_done), .sad_min(sad_min),
      .new_centre(new_centre), .done(done_a), .mv_x(mvx_a), .mv_y(mvy_a),
      .best_sad(bsad_a), .iter_count(iter_a), .hit_limit(hit_a)
   );

   hex_search_controller #(.MV_W(MV_W), .SEARCH_RANGE(16), .MAX_ITER(15), .SAD_W(SAD_W)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .fetch_req(fetch_req_b),
      .centre_x(cx_b), .centre_y(cy_b), .fetch_done(fetch_done), .sad_min(sad_min),
      .new_centre(new_centre), .done(done_b), .mv_x(mvx_b), .mv_y(mvy_b),
      .best_sad(bsad_b), .iter_count(iter_b), .hit_limit(hit_b)
   );

   logic m_busy, m_fetch, m_done, m_hit, o_fetch, o_done;
   logic [MV_W-1:0] m_cx, m_cy, m_mvx, m_mvy;
   logic [SAD_W-1:0] m_sad;
   logic [3:0] m_iter;

   assign m_busy  = sel ? busy_b : busy_a;
   assign m_fetch = sel ? fetch_req_b : fetch_req_a;
   assign m_done  = sel ? done_b : done_a;
   assign m_hit   = sel ? hit_b : hit_a;
   assign m_cx    = sel ? cx_b : cx_a;
   assign m_cy    = sel ? cy_b : cy_a;
   assign m_mvx   = sel ? mvx_b : mvx_a;
   assign m_mvy   = sel ? mvy_b : mvy_a;
   assign m_sad   = sel ? bsad_b : bsad_a;
   assign m_iter  = sel ? iter_b : iter_a;
   assign o_fetch = sel ? fetch_req_a : fetch_req_b;
   assign o_done  = sel ? done_a : done_b;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_fetch(input int x, input int y);
      pt_t p;
      p.x = x;
      p.y = y;
      exp_fetch.push_back(p);
   endtask

   task automatic push_done(input int mvx, input int mvy, input int sad, input int iter, input int hit);
      res_t r;
      r.mvx = mvx; r.mvy = mvy; r.sad = sad; r.iter = iter; r.hit = hit;
      exp_done.push_back(r);
   endtask

   task automatic do_start();
      @(negedge clk);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_fetch();
      int n = 0;
      while (!m_fetch && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!m_fetch) begin
         checks++;
         errors++;
         $display("FAIL fetch_timeout got no fetch_req within %0d cycles", n);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (m_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (m_busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout got busy=1 after %0d cycles", n);
      end
   endtask

   // One evaluation: wait for the fetch, respond a cycle later with the winner.
   task automatic run_iter(input int winner, input int sad);
      wait_fetch();
      @(negedge clk);
      @(negedge clk);
      fetch_done = 1'b1;
      new_centre = 3'(winner);
      sad_min    = SAD_W'(sad);
      @(negedge clk);
      fetch_done = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, int'(busy_a), 0);
      check({tag, "_fetch_req"}, int'(fetch_req_a), 0);
      check({tag, "_done"}, int'(done_a), 0);
      check({tag, "_centre_x"}, int'(cx_a), 0);
      check({tag, "_centre_y"}, int'(cy_a), 0);
      check({tag, "_mv_x"}, int'(mvx_a), 0);
      check({tag, "_mv_y"}, int'(mvy_a), 0);
      check({tag, "_best_sad"}, int'(bsad_a), 0);
      check({tag, "_iter_count"}, int'(iter_a), 0);
      check({tag, "_hit_limit"}, int'(hit_a), 0);
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (o_fetch || o_done) begin
               checks++;
               errors++;
               $display("FAIL idle_instance_activity got fetch=%0d done=%0d expected 0 0", o_fetch, o_done);
            end
            if (m_fetch) begin
               if (exp_fetch.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_fetch got centre (%0d,%0d) expected no fetch_req",
                           $signed(m_cx), $signed(m_cy));
               end else begin
                  pt_t p;
                  p = exp_fetch.pop_front();
                  check("fetch_centre_x", int'($signed(m_cx)), p.x);
                  check("fetch_centre_y", int'($signed(m_cy)), p.y);
               end
            end
            if (m_done) begin
               if (exp_done.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done got done=1 expected no done");
               end else begin
                  res_t r;
                  r = exp_done.pop_front();
                  check("done_mv_x", int'($signed(m_mvx)), r.mvx);
                  check("done_mv_y", int'($signed(m_mvy)), r.mvy);
                  check("done_best_sad", int'(m_sad), r.sad);
                  check("done_iter_count", int'(m_iter), r.iter);
                  check("done_hit_limit", int'(m_hit), r.hit);
               end
            end
         end
      join_none

      // Reset state
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Immediate convergence
      sel = 1'b0;
      push_fetch(0, 0);
      push_done(0, 0, 100, 1, 0);
      do_start();
      run_iter(0, 100);
      wait_idle();

      // Winners 1, 2, 0
      push_fetch(0, 0); push_fetch(2, 0); push_fetch(3, 2);
      push_done(3, 2, 150, 3, 0);
      do_start();
      run_iter(1, 300);
      run_iter(2, 200);
      run_iter(0, 150);
      wait_idle();

      // Abort in WAIT, stray fetch_done afterwards
      push_fetch(0, 0);
      do_start();
      wait_fetch();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero("abort");
      rst = 1'b0;
      fetch_done = 1'b1;
      new_centre = 3'd1;
      @(negedge clk);
      fetch_done = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_after", int'(busy_a), 0);
      check("abort_centre_x_after", int'(cx_a), 0);
      push_fetch(0, 0); push_fetch(1, -2);
      push_done(1, -2, 40, 2, 0);
      do_start();
      run_iter(6, 50);
      run_iter(0, 40);
      wait_idle();

      // x saturates at +16 and stalls on the 9th evaluation (MAX_ITER=15)
      sel = 1'b1;
      for (int i = 0; i <= 8; i++) push_fetch(2 * i, 0);
      push_done(16, 0, 120, 9, 0);
      do_start();
      for (int i = 0; i <= 8; i++) run_iter(1, 200 - 10 * i);
      wait_idle();

      // y saturates but x keeps moving until the 15-evaluation cap
      for (int i = 0; i <= 14; i++) push_fetch(i, (i <= 8) ? 2 * i : 16);
      push_done(15, 16, 5, 15, 1);
      do_start();
      for (int i = 0; i <= 14; i++) run_iter(2, 5);
      wait_idle();

      // Winner 4 until the 8-evaluation cap
      sel = 1'b0;
      for (int i = 0; i <= 7; i++) push_fetch(-2 * i, 0);
      push_done(-16, 0, 107, 8, 1);
      do_start();
      for (int i = 0; i <= 7; i++) run_iter(4, 100 + i);
      wait_idle();

      // start during WAIT and coincident with DONE is ignored
      push_fetch(0, 0); push_fetch(2, 0);
      push_done(2, 0, 55, 2, 0);
      do_start();
      run_iter(1, 60);
      wait_fetch();
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check("wait_start_busy", int'(busy_a), 1);
      check("wait_start_centre_x", int'($signed(cx_a)), 2);
      check("wait_start_centre_y", int'($signed(cy_a)), 0);
      fetch_done = 1'b1;
      new_centre = 3'd0;
      sad_min    = SAD_W'(55);
      @(negedge clk);
      fetch_done = 1'b0;
      @(negedge clk);
      check("done_cycle_done", int'(done_a), 1);
      start_a = 1'b1;
      @(negedge clk);
      check("after_done_busy", int'(busy_a), 0);
      check("after_done_mv_x", int'($signed(mvx_a)), 2);
      push_fetch(0, 0); push_fetch(-1, 2);
      push_done(-1, 2, 10, 2, 0);
      @(negedge clk);
      start_a = 1'b0;
      check("late_start_busy", int'(busy_a), 1);
      check("late_start_iter_cleared", int'(iter_a), 0);
      run_iter(3, 20);
      run_iter(0, 10);
      wait_idle();

      repeat (5) @(negedge clk);
      check("fetch_queue_left", exp_fetch.size(), 0);
      check("done_queue_left", exp_done.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
